// File: rtl/async_oneway_transmitter_pkg.sv
// Shared constants and types for the one-way inter-board link transmitter.
//   MESSAGE_SIZE : payload bits per frame
//   CHUNK_W      : link data width (must match the receiver)
//   NUM_CHUNKS   : chunks per frame, ceil(MESSAGE_SIZE / CHUNK_W)
//   BUF_W        : frame buffer width, payload zero-extended at the MSB end
package async_oneway_transmitter_pkg;

    localparam int unsigned MESSAGE_SIZE = 100;
    localparam int unsigned CHUNK_W      = 6;
    localparam int unsigned NUM_CHUNKS   = (MESSAGE_SIZE + CHUNK_W - 1) / CHUNK_W;
    localparam int unsigned BUF_W        = NUM_CHUNKS * CHUNK_W;
    localparam int unsigned IDX_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    // Frame buffer viewed as chunks; element k is chunk k on the link.
    typedef logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] frame_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        PULSE_HI  = 3'd2,
        PULSE_LO  = 3'd3,
        COMMIT_HI = 3'd4,
        COMMIT_LO = 3'd5
    } tx_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/async_oneway_transmitter_link_hold_timer.sv
// link_hold_timer: loadable down-counter with a zero flag. Times every strobe
// level, the data setup window and the idle refresh interval.
//   clk, rst_n : clock, async active-low reset (count resets to 0)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load (N-1 for an N-cycle interval)
//   count      : registered counter value; stops at 0
//   zero_c     : combinational, count == 0
module link_hold_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/async_oneway_transmitter.sv
// async_oneway_transmitter: sending end of the one-way inter-board link.
// Accepts one message over valid/ready, then sends it as CHUNK_W-bit chunks,
// LSB chunk first, each framed by a packet_pulse strobe, followed by one
// transmit_ctrl commit strobe. Every level is held long enough to survive
// the receiver's debouncers. All outputs are registered.
//   clk_send, rst_n : transmit clock, async active-low reset
//   send_valid      : message_in is valid
//   send_ready      : idle, a message can be accepted
//   message_in      : payload (MESSAGE_SIZE bits)
//   dout            : link data to the receiver
//   packet_pulse    : chunk strobe
//   transmit_ctrl   : frame commit strobe
//   send_done       : one-cycle pulse in the last cycle of a frame
// Optional build macro ASYNC_TX_REFRESH_EN: after REFRESH_CYCLES idle cycles
// the last accepted frame is retransmitted (never before the first accept).
module async_oneway_transmitter
    import async_oneway_transmitter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned REFRESH_CYCLES = 4096
) (
    input  logic                    clk_send,
    input  logic                    rst_n,
    input  logic                    send_valid,
    output logic                    send_ready,
    input  logic [MESSAGE_SIZE-1:0] message_in,
    output logic [CHUNK_W-1:0]      dout,
    output logic                    packet_pulse,
    output logic                    transmit_ctrl,
    output logic                    send_done
);

    // Timer is sized for the longest interval, refresh included.
    localparam int unsigned TMR_MAX = max_u(max_u(HOLD_CYCLES, SETUP_CYCLES), REFRESH_CYCLES);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    tx_state_t          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    frame_t             frame_q, frame_d;
    logic [CHUNK_W-1:0] dout_d;
    logic               done_d;
    logic               accept_c;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic [TMR_W-1:0]   tmr_count;
    logic               tmr_zero_c;

`ifdef ASYNC_TX_REFRESH_EN
    logic               have_frame_q;

    // Remembers that frame_q holds a real frame worth refreshing.
    always_ff @(posedge clk_send or negedge rst_n) begin
        if (!rst_n) begin
            have_frame_q <= 1'b0;
        end else if (accept_c) begin
            have_frame_q <= 1'b1;
        end
    end
`endif

    link_hold_timer #(
        .W (TMR_W)
    ) u_hold_timer (
        .clk      (clk_send),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (tmr_count),
        .zero_c   (tmr_zero_c)
    );

    // Next-state, next-output and frame buffer update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        dout_d   = dout;
        accept_c = send_valid && send_ready;
        // Timer is at 1 in the second-to-last COMMIT_LO cycle (HOLD_CYCLES >= 2).
        done_d   = (state_q == COMMIT_LO) && (tmr_count == TMR_W'(1));

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SETUP;
                    idx_d   = '0;
                    frame_d = frame_t'(BUF_W'(message_in));
                    dout_d  = frame_d[0];
                end
`ifdef ASYNC_TX_REFRESH_EN
                else if (have_frame_q && tmr_zero_c) begin
                    state_d = SETUP;
                    idx_d   = '0;
                    dout_d  = frame_q[0];
                end
`endif
            end
            SETUP: begin
                if (tmr_zero_c) state_d = PULSE_HI;
            end
            PULSE_HI: begin
                if (tmr_zero_c) state_d = PULSE_LO;
            end
            PULSE_LO: begin
                if (tmr_zero_c) begin
                    if (idx_q != LAST_IDX) begin
                        state_d = SETUP;
                        idx_d   = idx_q + IDX_W'(1);
                        dout_d  = frame_q[idx_d];
                    end else begin
                        state_d = COMMIT_HI;
                    end
                end
            end
            COMMIT_HI: begin
                if (tmr_zero_c) state_d = COMMIT_LO;
            end
            COMMIT_LO: begin
                if (tmr_zero_c) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timer reloads with N-1 on every state entry.
    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        case (state_d)
            SETUP:                                    tmr_load_val = TMR_W'(SETUP_CYCLES - 1);
            PULSE_HI, PULSE_LO, COMMIT_HI, COMMIT_LO: tmr_load_val = TMR_W'(HOLD_CYCLES - 1);
`ifdef ASYNC_TX_REFRESH_EN
            IDLE:                                     tmr_load_val = TMR_W'(REFRESH_CYCLES - 1);
`endif
            default:                                  tmr_load_val = '0;
        endcase
    end

    // State register and output registers, aligned with the state they describe.
    always_ff @(posedge clk_send or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            frame_q       <= '0;
            dout          <= '0;
            packet_pulse  <= 1'b0;
            transmit_ctrl <= 1'b0;
            send_done     <= 1'b0;
            send_ready    <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            dout          <= dout_d;
            packet_pulse  <= (state_d == PULSE_HI);
            transmit_ctrl <= (state_d == COMMIT_HI);
            send_done     <= done_d;
            send_ready    <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_async_oneway_transmitter.sv
// Bench for async_oneway_transmitter: three instances (fast timing, default
// timing, fast timing with a short refresh interval). A negedge monitor
// records chunk values and strobe widths of the selected instance; tasks push
// expected chunks at accept time and pop/compare them after the frame.
module tb_async_oneway_transmitter;
    import async_oneway_transmitter_pkg::*;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    sv     [NI];
    logic [MESSAGE_SIZE-1:0] msg    [NI];
    logic                    rdy    [NI];
    logic [CHUNK_W-1:0]      dout_w [NI];
    logic                    pp     [NI];
    logic                    tc     [NI];
    logic                    sd     [NI];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    async_oneway_transmitter #(.HOLD_CYCLES(2), .SETUP_CYCLES(1), .REFRESH_CYCLES(50000)) dut (
        .clk_send(clk), .rst_n(rst_n), .send_valid(sv[0]), .send_ready(rdy[0]),
        .message_in(msg[0]), .dout(dout_w[0]), .packet_pulse(pp[0]),
        .transmit_ctrl(tc[0]), .send_done(sd[0]));

    async_oneway_transmitter dut_def (
        .clk_send(clk), .rst_n(rst_n), .send_valid(sv[1]), .send_ready(rdy[1]),
        .message_in(msg[1]), .dout(dout_w[1]), .packet_pulse(pp[1]),
        .transmit_ctrl(tc[1]), .send_done(sd[1]));

    async_oneway_transmitter #(.HOLD_CYCLES(2), .SETUP_CYCLES(1), .REFRESH_CYCLES(10)) dut_ref (
        .clk_send(clk), .rst_n(rst_n), .send_valid(sv[2]), .send_ready(rdy[2]),
        .message_in(msg[2]), .dout(dout_w[2]), .packet_pulse(pp[2]),
        .transmit_ctrl(tc[2]), .send_done(sd[2]));

    // Scoreboard and monitor state
    logic [CHUNK_W-1:0] exp_q [$];
    logic [CHUNK_W-1:0] obs_q [$];
    int hi_q [$];
    int gap_q [$];
    int ctrl_q [$];
    int hi_run, lo_run, ctrl_run, overlap, done_cnt, tc_cnt;
    bit seen_fall;
    logic prev_pp = 1'b0, prev_tc = 1'b0;
    logic m_pp, m_tc;
    int mon_sel = 0;

    always @(negedge clk) begin
        m_pp = pp[mon_sel];
        m_tc = tc[mon_sel];
        if (m_pp && !prev_pp) begin
            obs_q.push_back(dout_w[mon_sel]);
            if (seen_fall) gap_q.push_back(lo_run);
        end
        if (!m_pp && prev_pp) begin
            hi_q.push_back(hi_run);
            hi_run    = 0;
            lo_run    = 0;
            seen_fall = 1'b1;
        end
        if (m_pp) hi_run++; else lo_run++;
        if (!m_tc && prev_tc) begin
            ctrl_q.push_back(ctrl_run);
            ctrl_run = 0;
        end
        if (m_tc) begin
            ctrl_run++;
            tc_cnt++;
        end
        if (m_pp && m_tc) overlap++;
        if (sd[mon_sel]) done_cnt++;
        prev_pp = m_pp;
        prev_tc = m_tc;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mon_clear(input int sel);
        mon_sel = sel;
        exp_q.delete(); obs_q.delete();
        hi_q.delete(); gap_q.delete(); ctrl_q.delete();
        hi_run = 0; lo_run = 0; ctrl_run = 0;
        overlap = 0; done_cnt = 0; tc_cnt = 0;
        seen_fall = 1'b0;
    endtask

    // Bench model: zero-extend, emit low chunk first.
    task automatic push_expected(input logic [MESSAGE_SIZE-1:0] m);
        logic [BUF_W-1:0] ext;
        ext = BUF_W'(m);
        for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
            exp_q.push_back(ext[CHUNK_W-1:0]);
            ext = ext >> CHUNK_W;
        end
    endtask

    task automatic do_accept(input int i, input logic [MESSAGE_SIZE-1:0] m, input bit hold,
                             output int a_cyc, output bit ok);
        ok    = 1'b0;
        a_cyc = 0;
        sv[i]  = 1'b1;
        msg[i] = m;
        for (int k = 0; k < 50; k++) begin
            if (rdy[i] === 1'b1) begin
                ok    = 1'b1;
                a_cyc = cyc;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL accept_timeout: send_ready stayed low on instance %0d", i);
        end else begin
            push_expected(m);
        end
        tick();
        if (!hold) sv[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit, output int d_cyc, output bit ok);
        ok    = 1'b0;
        d_cyc = 0;
        for (int k = 0; k < limit; k++) begin
            if (sd[i] === 1'b1) begin
                ok    = 1'b1;
                d_cyc = cyc;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL done_timeout: no send_done on instance %0d within %0d cycles", i, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b, expected 1", rdy[0]); end
        n_cmp++; if (dout_w[0] !== '0) begin n_bad++; $display("FAIL reset_dout: got %h, expected 00", dout_w[0]); end
        n_cmp++; if (pp[0] !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b, expected 0", pp[0]); end
        n_cmp++; if (tc[0] !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b, expected 0", tc[0]); end
        n_cmp++; if (sd[0] !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, expected 0", sd[0]); end
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single_frame();
        int a, d, bad_w;
        bit ok, okd;
        logic [CHUNK_W-1:0] e, o;
        mon_clear(0);
        do_accept(0, MESSAGE_SIZE'(1), 1'b0, a, ok);
        wait_done(0, 200, d, okd);
        n_cmp++; if (d - a != 89) begin n_bad++; $display("FAIL single_latency: got %0d, expected 89", d - a); end
        tick();
        n_cmp++; if (sd[0] !== 1'b0) begin n_bad++; $display("FAIL single_done_width: got %b, expected 0", sd[0]); end
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL single_ready_after: got %b, expected 1", rdy[0]); end
        n_cmp++; if (hi_q.size() != 17) begin n_bad++; $display("FAIL single_pulse_count: got %0d, expected 17", hi_q.size()); end
        bad_w = 0;
        foreach (hi_q[k]) if (hi_q[k] != 2) bad_w++;
        n_cmp++; if (bad_w != 0) begin n_bad++; $display("FAIL single_pulse_width: %0d pulses not 2 wide, expected 0", bad_w); end
        n_cmp++; if (ctrl_q.size() != 1) begin n_bad++; $display("FAIL single_ctrl_count: got %0d, expected 1", ctrl_q.size()); end
        else begin
            n_cmp++; if (ctrl_q[0] != 2) begin n_bad++; $display("FAIL single_ctrl_width: got %0d, expected 2", ctrl_q[0]); end
        end
        n_cmp++; if (overlap != 0) begin n_bad++; $display("FAIL single_overlap: got %0d, expected 0", overlap); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL single_chunk_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL single_chunk: got %h, expected %h", o, e); end
        end
    endtask

    task automatic test_pattern();
        logic [MESSAGE_SIZE-1:0] pa;
        logic [BUF_W-1:0] recon;
        logic [CHUNK_W-1:0] e, o;
        int a, d, n;
        bit ok, okd;
        pa    = 100'hABCDE_12345_6789A_BCDEF_01234;
        recon = '0;
        mon_clear(0);
        do_accept(0, pa, 1'b0, a, ok);
        wait_done(0, 200, d, okd);
        n = obs_q.size();
        n_cmp++; if (n != int'(NUM_CHUNKS)) begin n_bad++; $display("FAIL pattern_chunk_count: got %0d, expected %0d", n, NUM_CHUNKS); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            recon = {o, recon[BUF_W-1:CHUNK_W]};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (o !== e) begin n_bad++; $display("FAIL pattern_chunk: got %h, expected %h", o, e); end
            end
        end
        n_cmp++; if (recon[MESSAGE_SIZE-1:0] !== pa) begin n_bad++; $display("FAIL pattern_recon: got %h, expected %h", recon[MESSAGE_SIZE-1:0], pa); end
        n_cmp++; if (recon[BUF_W-1:MESSAGE_SIZE] !== '0) begin n_bad++; $display("FAIL pattern_pad: got %b, expected 0", recon[BUF_W-1:MESSAGE_SIZE]); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [MESSAGE_SIZE-1:0] pa, pb;
        logic [CHUNK_W-1:0] e, o;
        int a, d, b, d2;
        bit ok, okd, got_b;
        pa = 100'h13579_BDF02_468AC_E1357_9BDF0;
        pb = 100'hF0F0F_0F0F0_F0F0F_0F0F0_FFFFF;
        d = -100; b = 0; got_b = 1'b0;
        mon_clear(0);
        do_accept(0, pa, 1'b1, a, ok);
        msg[0] = pb;
        for (int k = 0; k < 200; k++) begin
            if (sd[0] === 1'b1) d = cyc;
            if (rdy[0] === 1'b1) begin b = cyc; got_b = 1'b1; break; end
            tick();
        end
        n_cmp++; if (d - a != 89) begin n_bad++; $display("FAIL busy_first_done: got %0d, expected 89", d - a); end
        n_cmp++; if (!got_b || b != d + 1) begin n_bad++; $display("FAIL busy_second_accept: got cycle %0d, expected %0d", b, d + 1); end
        if (got_b) push_expected(pb);
        tick();
        sv[0] = 1'b0;
        n_cmp++; if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL busy_ready_drop: got %b, expected 0", rdy[0]); end
        wait_done(0, 200, d2, okd);
        n_cmp++; if (d2 - b != 89) begin n_bad++; $display("FAIL busy_second_done: got %0d, expected 89", d2 - b); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL busy_chunk_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL busy_chunk: got %h, expected %h", o, e); end
        end
        tick();
    endtask

    task automatic test_midframe_reset();
        int a;
        bit ok, reached;
        mon_clear(0);
        do_accept(0, 100'h0_FEDC_BA98_7654_3210_FEDC_BA98, 1'b0, a, ok);
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (obs_q.size() == 9 && pp[0] === 1'b1) begin reached = 1'b1; break; end
            tick();
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL midreset_reach: chunk 8 strobe not seen, got %0d chunks", obs_q.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b, expected 1", rdy[0]); end
        n_cmp++; if (dout_w[0] !== '0) begin n_bad++; $display("FAIL midreset_dout: got %h, expected 00", dout_w[0]); end
        n_cmp++; if (pp[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_pulse: got %b, expected 0", pp[0]); end
        n_cmp++; if (tc[0] !== 1'b0 || sd[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_ctrl_done: got %b%b, expected 00", tc[0], sd[0]); end
        tick(); tick(); tick();
        rst_n = 1'b1;
        mon_clear(0);
        for (int k = 0; k < 120; k++) tick();
        n_cmp++; if (tc_cnt != 0 || done_cnt != 0) begin n_bad++; $display("FAIL midreset_no_commit: got ctrl %0d done %0d, expected 0 0", tc_cnt, done_cnt); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL midreset_no_resume: got %0d chunks, expected 0", obs_q.size()); end
    endtask

    task automatic test_default_timing();
        logic [MESSAGE_SIZE-1:0] m;
        logic [CHUNK_W-1:0] e, o;
        int a, d, bad_w, bad_g;
        bit ok, okd;
        m = '1;
        mon_clear(1);
        do_accept(1, m, 1'b0, a, ok);
        wait_done(1, 800, d, okd);
        n_cmp++; if (d - a != 644) begin n_bad++; $display("FAIL default_latency: got %0d, expected 644", d - a); end
        bad_w = 0; bad_g = 0;
        foreach (hi_q[k]) if (hi_q[k] != 16) bad_w++;
        foreach (gap_q[k]) if (gap_q[k] != 20) bad_g++;
        n_cmp++; if (hi_q.size() != 17 || bad_w != 0) begin n_bad++; $display("FAIL default_pulse_high: got %0d pulses, %0d not 16 wide, expected 17 and 0", hi_q.size(), bad_w); end
        n_cmp++; if (gap_q.size() != 16 || bad_g != 0) begin n_bad++; $display("FAIL default_pulse_low: got %0d gaps, %0d not 20 long, expected 16 and 0", gap_q.size(), bad_g); end
        n_cmp++; if (ctrl_q.size() != 1 || (ctrl_q.size() == 1 && ctrl_q[0] != 16)) begin n_bad++; $display("FAIL default_ctrl: got %0d strobes, expected one of 16 cycles", ctrl_q.size()); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL default_chunk_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL default_chunk: got %h, expected %h", o, e); end
        end
        tick();
    endtask

    task automatic test_refresh();
        logic [MESSAGE_SIZE-1:0] px;
        logic [CHUNK_W-1:0] e, o;
        int a, d1;
        bit ok, okd;
        px = 100'h12345_6789A_BCDEF_FEDCB_A9876;
        mon_clear(2);
        do_accept(2, px, 1'b0, a, ok);
        wait_done(2, 200, d1, okd);
        n_cmp++; if (d1 - a != 89) begin n_bad++; $display("FAIL refresh_first_done: got %0d, expected 89", d1 - a); end
`ifdef ASYNC_TX_REFRESH_EN
        begin
            int d2;
            bit ok2;
            push_expected(px);
            tick();
            wait_done(2, 300, d2, ok2);
            n_cmp++; if (d2 - d1 != 99) begin n_bad++; $display("FAIL refresh_retransmit_done: got %0d, expected 99", d2 - d1); end
        end
`else
        for (int k = 0; k < 150; k++) tick();
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL refresh_none_done: got %0d, expected 1", done_cnt); end
        n_cmp++; if (rdy[2] !== 1'b1) begin n_bad++; $display("FAIL refresh_none_ready: got %b, expected 1", rdy[2]); end
`endif
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL refresh_chunk_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL refresh_chunk: got %h, expected %h", o, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            sv[i]  = 1'b0;
            msg[i] = '0;
        end
        rst_n = 1'b0;
        test_reset();
        test_single_frame();
        test_pattern();
        test_back_to_back();
        test_midframe_reset();
        test_default_timing();
        test_refresh();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
